hazard_ctrl: RTL and testbench

- Drives the load/flush/bubble controls of the 5-stage pipeline registers: PC, IF/ID, and ID/EX bubble insertion.
- Keeps its own 2-entry scoreboard of in-flight register writes (EX and MEM positions), so it does not tap EX/MEM or MEM/WB register outputs.
- Detects load-use (and, without forwarding, all RAW) hazards and taken-branch flushes.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/hazard_ctrl_pkg.sv | 25 ++
 rtl/hazard_ctrl_sat_counter.sv | 17 +
 rtl/hazard_ctrl.sv | 57 +++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: scoreboard entry, control-bundle encodings and match helper for hazard_ctrl.
package hazard_ctrl_pkg;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] dst;
    logic              ld;
  } sb_entry_t;
  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_RUN   = 4'b1100;
  localparam ctrl_t CTRL_STALL = 4'b0001;
  localparam ctrl_t CTRL_FLUSH = 4'b1111;
  localparam sb_entry_t SB_INVALID = '0;
  function automatic logic sb_match(input sb_entry_t e, input logic use_rs,
                                    input logic [ADDR_W-1:0] rs, input logic use_rt,
                                    input logic [ADDR_W-1:0] rt);
    return e.v & ((use_rs & (rs == e.dst)) | (use_rt & (rt == e.dst)));
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control from a private EX/MEM write scoreboard.
// HAZARD_FWD_EN defined: only load-use stalls; undefined: any RAW on EX/MEM writers stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic              pc_load,
  output logic              ifid_load,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  sb_entry_t sb_ex_q, sb_ex_d, sb_mem_q, sb_mem_d;
  ctrl_t     ctrl;
  logic      hz, stall, flush;
  always_comb begin
`ifdef HAZARD_FWD_EN
    hz = id_valid & sb_ex_q.ld & sb_match(sb_ex_q, id_use_rs, id_rs, id_use_rt, id_rt);
`else
    hz = id_valid & (sb_match(sb_ex_q, id_use_rs, id_rs, id_use_rt, id_rt) |
                     sb_match(sb_mem_q, id_use_rs, id_rs, id_use_rt, id_rt));
`endif
    flush    = ex_branch_taken;
    stall    = hz & ~flush;
    ctrl     = flush ? CTRL_FLUSH : stall ? CTRL_STALL : CTRL_RUN;
    sb_mem_d = sb_ex_q;
    // $0 writes never enter the scoreboard, so $0 readers cannot match.
    sb_ex_d  = ctrl.idex_bubble ? SB_INVALID :
               '{v: id_valid & id_reg_write & (id_dst != REG_ZERO), dst: id_dst, ld: id_mem_read};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_ex_q  <= SB_INVALID;
      sb_mem_q <= SB_INVALID;
    end else begin
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
    end
  end
  assign {pc_load, ifid_load, ifid_flush, idex_bubble} = ctrl;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush), .cnt(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios for hazard_ctrl (CNT_W=4), expectations per HAZARD_FWD_EN.
module tb_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, ex_branch_taken;
  logic [4:0] id_rs, id_rt, id_dst;
  logic pc_load, ifid_load, ifid_flush, idex_bubble;
  logic [3:0] stall_cnt, flush_cnt;
  int pass = 0, total = 0;

  hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .pc_load(pc_load), .ifid_load(ifid_load),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] dst, input logic wr, input logic rd,
                       input logic br);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_dst = dst; id_reg_write = wr; id_mem_read = rd; ex_branch_taken = br;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1, 1'b0);
      total++;
      if ({stall_cnt, flush_cnt, pc_load, idex_bubble} !== {4'd0, 4'd0, 1'b1, 1'b0})
        $display("FAIL reset[%0d] cnt=%0d/%0d pc_load=%b bubble=%b want 0/0/1/0",
                 i, stall_cnt, flush_cnt, pc_load, idex_bubble);
      else pass++;
      cyc();
    end
    rst = 1'b1;
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    total++;
    if ({pc_load, ifid_load, ifid_flush, idex_bubble} !== 4'b1100)
      $display("FAIL reset_release ctrl=%b want 1100", {pc_load, ifid_load, ifid_flush, idex_bubble});
    else pass++;
    cyc();
  endtask

  task automatic test_load_use();
    logic [2:0] exp_stall;
    exp_stall = FWD ? 3'b100 : 3'b110;
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc();
    drive(1, 5, 1, 7, 1, 6, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({pc_load, ifid_load, idex_bubble} !== (exp_stall[2-i] ? 3'b001 : 3'b110))
        $display("FAIL load_use[%0d] pc/ifid/bubble=%b%b%b stall_expected=%b",
                 i, pc_load, ifid_load, idex_bubble, exp_stall[2-i]);
      else pass++;
      cyc();
    end
    total++;
    if (stall_cnt !== (FWD ? 4'd1 : 4'd2))
      $display("FAIL load_use_cnt stall_cnt=%0d want %0d", stall_cnt, FWD ? 1 : 2);
    else pass++;
  endtask

  task automatic test_alu_raw();
    logic [2:0] exp_stall;
    exp_stall = FWD ? 3'b000 : 3'b110;
    do_reset();
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
    cyc();
    drive(1, 4, 1, 3, 1, 8, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({pc_load, ifid_load, idex_bubble} !== (exp_stall[2-i] ? 3'b001 : 3'b110))
        $display("FAIL alu_raw[%0d] pc/ifid/bubble=%b%b%b stall_expected=%b",
                 i, pc_load, ifid_load, idex_bubble, exp_stall[2-i]);
      else pass++;
      cyc();
    end
    total++;
    if (stall_cnt !== (FWD ? 4'd0 : 4'd2))
      $display("FAIL alu_raw_cnt stall_cnt=%0d want %0d", stall_cnt, FWD ? 0 : 2);
    else pass++;
  endtask

  task automatic test_zero_dst();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc();
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({pc_load, ifid_load, idex_bubble} !== 3'b110)
        $display("FAIL zero_dst[%0d] pc/ifid/bubble=%b%b%b want 110", i, pc_load, ifid_load, idex_bubble);
      else pass++;
      cyc();
    end
    total++;
    if (stall_cnt !== 4'd0) $display("FAIL zero_dst_cnt stall_cnt=%0d want 0", stall_cnt);
    else pass++;
  endtask

  task automatic test_branch_during_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 1);
    total++;
    if ({pc_load, ifid_load, ifid_flush, idex_bubble} !== 4'b1111)
      $display("FAIL branch_stall ctrl=%b want 1111", {pc_load, ifid_load, ifid_flush, idex_bubble});
    else pass++;
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({flush_cnt, stall_cnt, pc_load, ifid_flush} !== {4'd1, 4'd0, 1'b1, 1'b0})
      $display("FAIL branch_cnt flush=%0d stall=%0d pc_load=%b flush_o=%b want 1/0/1/0",
               flush_cnt, stall_cnt, pc_load, ifid_flush);
    else pass++;
    cyc();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    cyc();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
    total++;
    if (pc_load !== 1'b0) $display("FAIL mid_stall_pre pc_load=%b want 0", pc_load);
    else pass++;
    rst = 1'b0;
    #1;
    total++;
    if ({pc_load, idex_bubble, stall_cnt} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL mid_stall_rst pc_load=%b bubble=%b stall=%0d want 1/0/0", pc_load, idex_bubble, stall_cnt);
    else pass++;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 5, 1, 0, 0, 5, 1, 1, 0);
    repeat (4) cyc();
    total++;
    if (stall_cnt !== 4'd2) $display("FAIL sat_mid stall_cnt=%0d want 2", stall_cnt);
    else pass++;
    repeat (36) cyc();
    total++;
    if (stall_cnt !== 4'd15) $display("FAIL sat_stall stall_cnt=%0d want 15", stall_cnt);
    else pass++;
    drive(1, 5, 1, 0, 0, 5, 1, 1, 1);
    repeat (19) cyc();
    total++;
    if ({flush_cnt, stall_cnt} !== {4'd15, 4'd15})
      $display("FAIL sat_flush flush=%0d stall=%0d want 15/15", flush_cnt, stall_cnt);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_raw();
    test_zero_dst();
    test_branch_during_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
